// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register reservation scoreboard.
// Decode reads operands and checks hazards combinationally; write-back updates data and releases.
module regfile_scoreboard #(
  parameter int W_RD  = 5,
  parameter int W_OPR = 32,
  parameter int W_CNT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_RD-1:0]  r0_i,
  input  logic [W_RD-1:0]  r1_i,
  input  logic             chk_v_i,
  input  logic             use_r0_i,
  input  logic             use_r1_i,
  input  logic             use_rd_i,
  output logic [W_OPR-1:0] r_opr0_o,
  output logic [W_OPR-1:0] r_opr1_o,
  output logic             reserved_o,
  input  logic             w_reserve_i,
  input  logic             wb_en_i,
  input  logic [W_RD-1:0]  wb_addr_i,
  input  logic [W_OPR-1:0] wb_data_i,
  output logic [W_CNT-1:0] rsv_cnt_o
);

  localparam int NREG = 1 << W_RD;
  localparam logic [W_CNT-1:0] NREG_CNT = W_CNT'(NREG);

  // Handshake: wb_en_i and w_reserve_i are valid-only strobes with an
  // implicit always-ready sink; each is consumed on the rising edge it is
  // high. Decode must gate w_reserve_i with !reserved_o, so reserved_o
  // never looks at w_reserve_i.

  logic [W_OPR-1:0] rf [NREG];
  logic [NREG-1:0]  rsv;
  logic [W_CNT-1:0] rsv_cnt;

  logic [NREG-1:0]  wb_mask;
  logic [NREG-1:0]  rs_mask;
  logic [NREG-1:0]  eff;
  logic [NREG-1:0]  rsv_next;
  logic             wb_hit0;
  logic             wb_hit1;
  logic             same_reg;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [W_CNT-1:0] cnt_next;

  always_comb begin
    wb_mask = '0;
    if (wb_en_i) wb_mask[wb_addr_i] = 1'b1;
  end

  always_comb begin
    rs_mask = '0;
    if (w_reserve_i) rs_mask[r0_i] = 1'b1;
  end

  // A same-cycle write-back hides the reservation it is about to release.
  assign eff      = rsv & ~wb_mask;
  assign rsv_next = (rsv & ~wb_mask) | rs_mask;

  assign wb_hit0  = wb_en_i && (wb_addr_i == r0_i);
  assign wb_hit1  = wb_en_i && (wb_addr_i == r1_i);
  assign same_reg = w_reserve_i && wb_hit0;

  assign r_opr0_o = wb_hit0 ? wb_data_i : rf[r0_i];
  assign r_opr1_o = wb_hit1 ? wb_data_i : rf[r1_i];

  assign reserved_o = chk_v_i & ((use_r0_i & eff[r0_i]) |
                                 (use_r1_i & eff[r1_i]) |
                                 (use_rd_i & eff[r0_i]));

  // Release-then-re-reserve of a set bit leaves the population unchanged.
  assign cnt_inc  = w_reserve_i && !rsv[r0_i];
  assign cnt_dec  = wb_en_i && rsv[wb_addr_i] && !same_reg;
  assign cnt_next = rsv_cnt + W_CNT'(cnt_inc) - W_CNT'(cnt_dec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en_i) begin
      rf[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsv     <= '0;
      rsv_cnt <= '0;
    end else begin
      rsv     <= rsv_next;
      rsv_cnt <= cnt_next;
    end
  end

  assign rsv_cnt_o = rsv_cnt;

`ifndef SYNTHESIS
  a_double_reserve: assert property (@(posedge clk) disable iff (!reset)
    !(w_reserve_i && rsv[r0_i] && !wb_hit0))
    else $error("reserve of already-reserved register %0d", r0_i);

  a_cnt_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(cnt_dec && !cnt_inc && rsv_cnt == '0))
    else $error("reservation counter underflow");

  a_cnt_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(cnt_inc && !cnt_dec && rsv_cnt == NREG_CNT))
    else $error("reservation counter overflow");

  a_cnt_matches: assert property (@(posedge clk) disable iff (!reset)
    rsv_cnt == W_CNT'($countones(rsv)))
    else $error("reservation counter out of step with scoreboard");
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, reservation hazards,
// same-cycle release/reserve, counter sequencing and asynchronous reset.
module tb_regfile_scoreboard;

  localparam int W_RD  = 5;
  localparam int W_OPR = 32;
  localparam int W_CNT = 6;
  localparam int NREG  = 1 << W_RD;

  logic             clk;
  logic             reset;
  logic [W_RD-1:0]  r0_i;
  logic [W_RD-1:0]  r1_i;
  logic             chk_v_i;
  logic             use_r0_i;
  logic             use_r1_i;
  logic             use_rd_i;
  logic [W_OPR-1:0] r_opr0_o;
  logic [W_OPR-1:0] r_opr1_o;
  logic             reserved_o;
  logic             w_reserve_i;
  logic             wb_en_i;
  logic [W_RD-1:0]  wb_addr_i;
  logic [W_OPR-1:0] wb_data_i;
  logic [W_CNT-1:0] rsv_cnt_o;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.W_RD(W_RD), .W_OPR(W_OPR), .W_CNT(W_CNT)) dut (
    .clk(clk), .reset(reset),
    .r0_i(r0_i), .r1_i(r1_i),
    .chk_v_i(chk_v_i), .use_r0_i(use_r0_i), .use_r1_i(use_r1_i), .use_rd_i(use_rd_i),
    .r_opr0_o(r_opr0_o), .r_opr1_o(r_opr1_o), .reserved_o(reserved_o),
    .w_reserve_i(w_reserve_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rsv_cnt_o(rsv_cnt_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1-2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_i = '0; r1_i = '0;
    chk_v_i = 1'b0; use_r0_i = 1'b0; use_r1_i = 1'b0; use_rd_i = 1'b0;
    w_reserve_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    r0_i = 5'd3; r1_i = 5'd7;
    chk_v_i = 1'b1; use_r0_i = 1'b1; use_r1_i = 1'b1; use_rd_i = 1'b1;
    #1;
    checks++; if (r_opr0_o !== 32'h0) begin errors++; $display("FAIL reset_opr0 got %h want %h", r_opr0_o, 32'h0); end
    checks++; if (r_opr1_o !== 32'h0) begin errors++; $display("FAIL reset_opr1 got %h want %h", r_opr1_o, 32'h0); end
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL reset_reserved got %b want 0", reserved_o); end
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", rsv_cnt_o); end
    tick();
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    r0_i = 5'd5; r1_i = 5'd7;
    #1;
    checks++; if (r_opr0_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_opr0 got %h want deadbeef", r_opr0_o); end
    checks++; if (r_opr1_o !== 32'h0) begin errors++; $display("FAIL bypass_other got %h want 0", r_opr1_o); end
    tick();
    idle_inputs();
    r0_i = 5'd5; r1_i = 5'd5;
    #1;
    checks++; if (r_opr0_o !== 32'hDEADBEEF) begin errors++; $display("FAIL array_opr0 got %h want deadbeef", r_opr0_o); end
    checks++; if (r_opr1_o !== 32'hDEADBEEF) begin errors++; $display("FAIL array_opr1 got %h want deadbeef", r_opr1_o); end
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL unreserved_wb_cnt got %0d want 0", rsv_cnt_o); end
    tick();
  endtask

  task automatic test_reserve_release();
    idle_inputs();
    r0_i = 5'd4; w_reserve_i = 1'b1;
    chk_v_i = 1'b1; use_r1_i = 1'b1; r1_i = 5'd4;
    #1;
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL reserve_not_yet got %b want 0", reserved_o); end
    tick();
    w_reserve_i = 1'b0;
    #1;
    checks++; if (reserved_o !== 1'b1) begin errors++; $display("FAIL reserve_visible got %b want 1", reserved_o); end
    checks++; if (rsv_cnt_o !== 6'd1) begin errors++; $display("FAIL reserve_cnt got %0d want 1", rsv_cnt_o); end
    wb_en_i = 1'b1; wb_addr_i = 5'd4; wb_data_i = 32'h12;
    #1;
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL release_hazard got %b want 0", reserved_o); end
    checks++; if (r_opr1_o !== 32'h12) begin errors++; $display("FAIL release_bypass got %h want 12", r_opr1_o); end
    tick();
    wb_en_i = 1'b0;
    #1;
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL release_cnt got %0d want 0", rsv_cnt_o); end
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL release_settled got %b want 0", reserved_o); end
    checks++; if (r_opr1_o !== 32'h12) begin errors++; $display("FAIL release_array got %h want 12", r_opr1_o); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    r0_i = 5'd9; w_reserve_i = 1'b1;
    tick();
    w_reserve_i = 1'b0;
    #1;
    checks++; if (rsv_cnt_o !== 6'd1) begin errors++; $display("FAIL same_pre_cnt got %0d want 1", rsv_cnt_o); end
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h55; w_reserve_i = 1'b1;
    tick();
    idle_inputs();
    r0_i = 5'd9; chk_v_i = 1'b1; use_rd_i = 1'b1;
    #1;
    checks++; if (rsv_cnt_o !== 6'd1) begin errors++; $display("FAIL same_cnt got %0d want 1", rsv_cnt_o); end
    checks++; if (r_opr0_o !== 32'h55) begin errors++; $display("FAIL same_data got %h want 55", r_opr0_o); end
    checks++; if (reserved_o !== 1'b1) begin errors++; $display("FAIL same_still_reserved got %b want 1", reserved_o); end
    idle_inputs();
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h56;
    tick();
    wb_en_i = 1'b0;
    #1;
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL same_cleanup_cnt got %0d want 0", rsv_cnt_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W_RD-1:0]  rs_addr [4]  = '{5'd1, 5'd2, 5'd3, 5'd6};
    logic [W_CNT-1:0] exp_cnt [4]  = '{6'd1, 6'd2, 6'd3, 6'd3};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      r0_i = rs_addr[i]; w_reserve_i = 1'b1;
      wb_en_i = (i == 3); wb_addr_i = 5'd2; wb_data_i = 32'h22;
      tick();
      w_reserve_i = 1'b0; wb_en_i = 1'b0;
      #1;
      checks++; if (rsv_cnt_o !== exp_cnt[i]) begin errors++; $display("FAIL b2b_cnt step %0d got %0d want %0d", i, rsv_cnt_o, exp_cnt[i]); end
    end
    r0_i = 5'd6; chk_v_i = 1'b1; use_rd_i = 1'b1;
    #1;
    checks++; if (reserved_o !== 1'b1) begin errors++; $display("FAIL b2b_waw6 got %b want 1", reserved_o); end
    use_rd_i = 1'b0; use_r0_i = 1'b1; r0_i = 5'd2;
    #1;
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL b2b_released2 got %b want 0", reserved_o); end
    checks++; if (r_opr0_o !== 32'h22) begin errors++; $display("FAIL b2b_data2 got %h want 22", r_opr0_o); end
    r0_i = 5'd1;
    #1;
    checks++; if (reserved_o !== 1'b1) begin errors++; $display("FAIL b2b_raw1 got %b want 1", reserved_o); end
    // Leave only regs 1 and 2 reserved for the reset scenario.
    idle_inputs();
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h33; r0_i = 5'd2; w_reserve_i = 1'b1;
    tick();
    w_reserve_i = 1'b0; wb_addr_i = 5'd6; wb_data_i = 32'h66;
    tick();
    wb_en_i = 1'b0;
    #1;
    checks++; if (rsv_cnt_o !== 6'd2) begin errors++; $display("FAIL b2b_final_cnt got %0d want 2", rsv_cnt_o); end
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    chk_v_i = 1'b1; use_r0_i = 1'b1; use_r1_i = 1'b1; r0_i = 5'd1; r1_i = 5'd2;
    #1;
    checks++; if (reserved_o !== 1'b1) begin errors++; $display("FAIL areset_pre_hazard got %b want 1", reserved_o); end
    #1 reset = 1'b0;
    #1;
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", rsv_cnt_o); end
    checks++; if (reserved_o !== 1'b0) begin errors++; $display("FAIL areset_hazard got %b want 0", reserved_o); end
    for (int k = 0; k < NREG; k++) begin
      r0_i = W_RD'(k); r1_i = W_RD'(NREG - 1 - k);
      #1;
      checks++; if (r_opr0_o !== 32'h0) begin errors++; $display("FAIL areset_reg %0d got %h want 0", k, r_opr0_o); end
      checks++; if (r_opr1_o !== 32'h0) begin errors++; $display("FAIL areset_reg %0d got %h want 0", NREG - 1 - k, r_opr1_o); end
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++; if (rsv_cnt_o !== 6'd0) begin errors++; $display("FAIL areset_after_cnt got %0d want 0", rsv_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_reserve_release();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
